tank_key_ctrl: RTL and testbench
================================

// Module: tank_key_ctrl
// PURPOSE
// - Upstream of the tank position stage. Turns the PS/2 receiver byte stream into the 4-bit direction vector and a fire pulse.
// - Decodes make/break codes, including the E0 and F0 prefixes. Tracks which keys are held.
// - Only one direction is active at a time: the most recently pressed held arrow wins.
// - Fire is rate-limited by a frame-counted cooldown.
// PARAMETERS
// - FIRE_COOLDOWN_FRAMES, default 15: frames after a fire pulse during which fire is suppressed.
// - CODE_UP, default 8'h75: extended (E0) scan code for the up arrow.
// - CODE_DOWN, default 8'h72: extended scan code for the down arrow.
// - CODE_LEFT, default 8'h6B: extended scan code for the left arrow.
// - CODE_RIGHT, default 8'h74: extended scan code for the right arrow.
// - CODE_FIRE, default 8'h29: non-extended scan code (space).
// PORTS
// - clk, in, 1: system clock. All logic is on the rising edge.
// - reset, in, 1: asynchronous, active-high reset.
// - startOfFrame, in, 1: one-cycle pulse per video frame.
// - dinNew, in, 1: one-cycle strobe, dataIn is valid.
// - dataIn, in, 8: byte from the PS/2 receiver.
// - inputKeyPressed, out, 4: one-hot or zero.
//   - [0] down, [1] up, [2] left, [3] right.
// - firePulse, out, 1: one-cycle pulse requesting a shot.
// - heldKeys, out, 5: raw held bitmap {fire, right, left, up, down}, for debug.
// BEHAVIOUR
// - Reset: FSM to IDLE. heldKeys, inputKeyPressed, firePulse, the last-pressed register and the cooldown counter all go to 0.
// - Prefix FSM, advanced only on cycles where dinNew=1:
//   - IDLE -E0-> EXT; IDLE -F0-> BRK; IDLE -other-> make(code, ext=0), stay in IDLE.
//   - EXT -F0-> EXT_BRK; EXT -other-> make(code, ext=1), go to IDLE.
//   - BRK -any-> break(code, ext=0), go to IDLE.
//   - EXT_BRK -any-> break(code, ext=1), go to IDLE.
//   - E0 received while in EXT or EXT_BRK: ignored, state held.
// - Key matching: arrows match only with ext=1; fire matches only with ext=0. Unmapped codes are consumed with no effect.
// - Make of an arrow:
//   - Set its held bit.
//   - If the bit was previously 0, that arrow becomes lastDir.
//   - A typematic repeat (bit already 1) does not change lastDir.
// - Break of an arrow:
//   - Clear its held bit.
//   - If it was lastDir, lastDir becomes the highest-priority remaining held arrow, in order up > down > left > right, or none.
// - inputKeyPressed is registered: one-hot of lastDir, or 4'b0000. It updates the cycle after the dinNew byte that completes the code.
//   - Latency: 1 clk from the final byte.
// - Fire:
//   - firePulse=1 for exactly one cycle, the cycle after a fire make whose held bit was 0 and with cooldown==0.
//   - On that pulse, cooldown loads FIRE_COOLDOWN_FRAMES and decrements by 1 on each startOfFrame until it reaches 0 (saturates at 0).
//   - Typematic repeats never fire. A fire make during cooldown sets the held bit but emits no pulse. The key must be released and re-pressed.
// - Simultaneous events: dinNew and startOfFrame in the same cycle are both applied. A decrement that reaches 0 in the same cycle as a qualifying make still blocks that make (compare uses the pre-decrement value).
// - Reset asserted mid-sequence (e.g. after E0): the FSM returns to IDLE and the partial code is discarded.
// STRUCTURE
// - Shared package tank_pkg:
//   - typedef enum {IDLE, EXT, BRK, EXT_BRK} ps2_state_t
//   - typedef enum {DIR_NONE, DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT} dir_t
//   - the constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0
// - One sub-module, ps2_code_fsm: prefix FSM emitting codeValid, isBreak, isExt and code[7:0].
// - The held/last-pressed arbitration and the fire cooldown stay in this module.
// TESTING
// - E0 75 -> inputKeyPressed=4'b0010 one clk after the last strobe. Then E0 F0 75 -> 4'b0000.
// - Hold up (E0 75), then E0 6B -> 4'b0100. Break left (E0 F0 6B) -> reverts to 4'b0010, since up is still held.
// - Repeated E0 75 x5 while held -> output constant at 4'b0010, lastDir unchanged.
// - 29 -> one firePulse. F0 29, then 29 within 15 frames -> no pulse.
//   - After 15 startOfFrame pulses, F0 29 then 29 -> pulse.
// - 75 without E0 (keypad 8) -> no direction. E0 29 -> no fire. E0 E0 72 -> 4'b0001.
// - Send E0, assert reset for 2 clks, then 72 -> no output change: 72 is decoded as non-extended and is unmapped.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared types and constants for the tank keyboard front end.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package tank_pkg;

  // Scan-code prefix FSM states.
  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_t;

  // Currently selected direction. DIR_NONE means no arrow is held.
  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_DOWN,
    DIR_UP,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Arrow bitmap layout shared by heldKeys[3:0] and inputKeyPressed:
  // [0] down, [1] up, [2] left, [3] right.
  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] v;
    v = 4'b0000;
    case (d)
      DIR_DOWN:  v = 4'b0001;
      DIR_UP:    v = 4'b0010;
      DIR_LEFT:  v = 4'b0100;
      DIR_RIGHT: v = 4'b1000;
      default:   v = 4'b0000;
    endcase
    return v;
  endfunction

  // Highest-priority set arrow, order up > down > left > right.
  function automatic dir_t highest_held(input logic [3:0] h);
    dir_t d;
    d = DIR_NONE;
    if (h[1])      d = DIR_UP;
    else if (h[0]) d = DIR_DOWN;
    else if (h[2]) d = DIR_LEFT;
    else if (h[3]) d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/tank_key_ctrl_ps2_code_fsm.sv
// Purpose: PS/2 prefix tracker; folds E0/F0 prefixes into one decoded code event.
// Latency: 0 clk -- codeValid is combinational on the strobe carrying the final byte.
// Backpressure: none; advances only on dinNew, every strobed byte is consumed.
// Ports: clk, reset (async, active-high), dinNew/dataIn byte strobe in;
//        codeValid/isBreak/isExt/code describe a completed code for one cycle.
module ps2_code_fsm
  import tank_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dinNew,
  input  logic [7:0] dataIn,
  output logic       codeValid,
  output logic       isBreak,
  output logic       isExt,
  output logic [7:0] code
);

  ps2_state_t state, nextState;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    codeValid = 1'b0;
    isBreak   = 1'b0;
    isExt     = 1'b0;
    code      = dataIn;
    if (dinNew) begin
      case (state)
        IDLE: begin
          if (dataIn == PS2_EXT)      nextState = EXT;
          else if (dataIn == PS2_BRK) nextState = BRK;
          else                        codeValid = 1'b1;
        end
        EXT: begin
          // A repeated E0 is absorbed; the extended context is kept.
          if (dataIn == PS2_EXT) begin
            nextState = EXT;
          end else if (dataIn == PS2_BRK) begin
            nextState = EXT_BRK;
          end else begin
            codeValid = 1'b1;
            isExt     = 1'b1;
            nextState = IDLE;
          end
        end
        BRK: begin
          codeValid = 1'b1;
          isBreak   = 1'b1;
          nextState = IDLE;
        end
        EXT_BRK: begin
          if (dataIn == PS2_EXT) begin
            nextState = EXT_BRK;
          end else begin
            codeValid = 1'b1;
            isBreak   = 1'b1;
            isExt     = 1'b1;
            nextState = IDLE;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tank_key_ctrl.sv
// Purpose: PS/2 byte stream -> one-hot tank direction (last pressed arrow wins) + rate-limited fire pulse.
// Latency: 1 clk from the strobe of the final byte of a code to inputKeyPressed/firePulse.
// Backpressure: none; every dinNew byte is consumed in its cycle, startOfFrame is never stalled.
// Ports: clk, reset (async, active-high), startOfFrame frame tick, dinNew/dataIn PS/2 bytes;
//        inputKeyPressed[3:0] {right,left,up,down} one-hot or zero, firePulse,
//        heldKeys[4:0] {fire,right,left,up,down} raw held bitmap.
module tank_key_ctrl
  import tank_pkg::*;
#(
  parameter int         FIRE_COOLDOWN_FRAMES = 15,
  parameter logic [7:0] CODE_UP    = 8'h75,
  parameter logic [7:0] CODE_DOWN  = 8'h72,
  parameter logic [7:0] CODE_LEFT  = 8'h6B,
  parameter logic [7:0] CODE_RIGHT = 8'h74,
  parameter logic [7:0] CODE_FIRE  = 8'h29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       dinNew,
  input  logic [7:0] dataIn,
  output logic [3:0] inputKeyPressed,
  output logic       firePulse,
  output logic [4:0] heldKeys
);

  localparam int CW = (FIRE_COOLDOWN_FRAMES < 1) ? 1 : $clog2(FIRE_COOLDOWN_FRAMES + 1);
  localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(FIRE_COOLDOWN_FRAMES);

  logic       codeValid;
  logic       isBreak;
  logic       isExt;
  logic [7:0] code;

  ps2_code_fsm u_ps2_code_fsm (
    .clk       (clk),
    .reset     (reset),
    .dinNew    (dinNew),
    .dataIn    (dataIn),
    .codeValid (codeValid),
    .isBreak   (isBreak),
    .isExt     (isExt),
    .code      (code)
  );

  logic [4:0]    held, heldNext;
  dir_t          lastDir, lastNext;
  logic [CW-1:0] cooldown, cooldownNext;
  logic [3:0]    arrowHit;
  logic          fireHit;
  logic          fireNow;

  // Arrows are only recognised behind E0, fire only without it.
  always_comb begin
    arrowHit    = 4'b0000;
    arrowHit[0] = codeValid && isExt && (code == CODE_DOWN);
    arrowHit[1] = codeValid && isExt && (code == CODE_UP);
    arrowHit[2] = codeValid && isExt && (code == CODE_LEFT);
    arrowHit[3] = codeValid && isExt && (code == CODE_RIGHT);
    fireHit     = codeValid && !isExt && (code == CODE_FIRE);
  end

  always_comb begin
    heldNext = held;
    lastNext = lastDir;
    fireNow  = 1'b0;

    if (arrowHit != 4'b0000) begin
      if (!isBreak) begin
        heldNext[3:0] = held[3:0] | arrowHit;
        // Only a fresh press retargets; typematic repeats leave lastDir alone.
        if ((held[3:0] & arrowHit) == 4'b0000)
          lastNext = highest_held(arrowHit);
      end else begin
        heldNext[3:0] = held[3:0] & ~arrowHit;
        if (dir_onehot(lastDir) == arrowHit)
          lastNext = highest_held(heldNext[3:0]);
      end
    end

    if (fireHit) begin
      if (!isBreak) begin
        heldNext[4] = 1'b1;
        // Pre-decrement cooldown is used, so a frame tick in this same
        // cycle cannot open the gate early.
        fireNow = !held[4] && (cooldown == '0);
      end else begin
        heldNext[4] = 1'b0;
      end
    end
  end

  always_comb begin
    cooldownNext = cooldown;
    if (fireNow)
      cooldownNext = COOLDOWN_LOAD;
    else if (startOfFrame && (cooldown != '0))
      cooldownNext = cooldown - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held            <= '0;
      lastDir         <= DIR_NONE;
      inputKeyPressed <= 4'b0000;
      firePulse       <= 1'b0;
      cooldown        <= '0;
    end else begin
      held            <= heldNext;
      lastDir         <= lastNext;
      inputKeyPressed <= dir_onehot(lastNext);
      firePulse       <= fireNow;
      cooldown        <= cooldownNext;
    end
  end

  assign heldKeys = held;

endmodule

// File: tb/tb_tank_key_ctrl.sv
// Directed bench for tank_key_ctrl: hand-computed expectations per byte sequence.
// Inputs change and outputs are sampled on the falling edge.
// Ends with a single summary line.
module tb_tank_key_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       dinNew = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic [3:0] inputKeyPressed;
  logic       firePulse;
  logic [4:0] heldKeys;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tank_key_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .dinNew          (dinNew),
    .dataIn          (dataIn),
    .inputKeyPressed (inputKeyPressed),
    .firePulse       (firePulse),
    .heldKeys        (heldKeys)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle byte strobe; returns on the falling edge after the clock edge
  // that consumed the byte, so registered outputs are already updated.
  task automatic send(input logic [7:0] b, input logic sof);
    @(negedge clk);
    dinNew = 1'b1;
    dataIn = b;
    startOfFrame = sof;
    @(negedge clk);
    dinNew = 1'b0;
    startOfFrame = 1'b0;
  endtask

  task automatic frame_tick();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic check_dir(input string tag, input logic [3:0] exp);
    check(tag, 8'(inputKeyPressed), 8'(exp));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dir", 8'(inputKeyPressed), 8'h00);
    check("reset_fire", 8'(firePulse), 8'h00);
    check("reset_held", 8'(heldKeys), 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Up press / release.
    send(8'hE0, 1'b0);
    check_dir("up_prefix_only", 4'b0000);
    send(8'h75, 1'b0);
    check_dir("up_make", 4'b0010);
    check("up_held", 8'(heldKeys), 8'h02);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0);
    check_dir("up_break_partial", 4'b0010);
    send(8'h75, 1'b0);
    check_dir("up_break", 4'b0000);
    check("up_break_held", 8'(heldKeys), 8'h00);

    // Up held, left pressed and released.
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    send(8'hE0, 1'b0); send(8'h6B, 1'b0);
    check_dir("left_over_up", 4'b0100);
    check("up_left_held", 8'(heldKeys), 8'h06);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h6B, 1'b0);
    check_dir("left_break_revert_up", 4'b0010);

    // Typematic repeats of up.
    for (int i = 0; i < 5; i++) begin
      send(8'hE0, 1'b0); send(8'h75, 1'b0);
      check_dir("up_repeat", 4'b0010);
    end

    // Down pressed on top of up; repeat of up must not steal it back.
    send(8'hE0, 1'b0); send(8'h72, 1'b0);
    check_dir("down_over_up", 4'b0001);
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    check_dir("up_repeat_keeps_down", 4'b0001);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h72, 1'b0);
    check_dir("down_break_to_up", 4'b0010);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    check_dir("all_released", 4'b0000);

    // Priority on release: hold left, right, down; drop down -> left wins.
    send(8'hE0, 1'b0); send(8'h6B, 1'b0);
    send(8'hE0, 1'b0); send(8'h74, 1'b0);
    check_dir("right_make", 4'b1000);
    send(8'hE0, 1'b0); send(8'h72, 1'b0);
    check("three_held", 8'(heldKeys), 8'h0D);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h72, 1'b0);
    check_dir("prio_left_over_right", 4'b0100);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h6B, 1'b0);
    check_dir("prio_right_left", 4'b1000);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h74, 1'b0);
    check_dir("prio_none", 4'b0000);

    // Fire and cooldown (15 frames).
    send(8'h29, 1'b0);
    check("fire_first", 8'(firePulse), 8'h01);
    @(negedge clk);
    check("fire_one_cycle", 8'(firePulse), 8'h00);
    send(8'h29, 1'b0);
    check("fire_typematic", 8'(firePulse), 8'h00);
    send(8'hF0, 1'b0); send(8'h29, 1'b0);
    check("fire_release_held", 8'(heldKeys), 8'h00);
    send(8'h29, 1'b0);
    check("fire_in_cooldown", 8'(firePulse), 8'h00);
    check("fire_held_in_cooldown", 8'(heldKeys), 8'h10);
    send(8'hF0, 1'b0); send(8'h29, 1'b0);
    repeat (14) frame_tick();
    // Cooldown is 1: the last tick coincides with the make and still blocks it.
    send(8'h29, 1'b1);
    check("fire_blocked_same_cycle", 8'(firePulse), 8'h00);
    send(8'hF0, 1'b0); send(8'h29, 1'b0);
    send(8'h29, 1'b0);
    check("fire_after_cooldown", 8'(firePulse), 8'h01);
    send(8'hF0, 1'b0); send(8'h29, 1'b0);
    check("fire_released", 8'(heldKeys), 8'h00);

    // Extension mismatches and double E0.
    send(8'h75, 1'b0);
    check_dir("keypad8_no_dir", 4'b0000);
    check("keypad8_no_held", 8'(heldKeys), 8'h00);
    send(8'hE0, 1'b0); send(8'h29, 1'b0);
    check("ext_29_no_fire", 8'(firePulse), 8'h00);
    check("ext_29_no_held", 8'(heldKeys), 8'h00);
    send(8'hE0, 1'b0); send(8'hE0, 1'b0); send(8'h72, 1'b0);
    check_dir("double_e0_down", 4'b0001);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'hE0, 1'b0); send(8'h72, 1'b0);
    check_dir("e0_in_ext_brk_ignored", 4'b0000);

    // Reset mid-code discards the E0 prefix.
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    check_dir("pre_reset_up", 4'b0010);
    send(8'hE0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_dir("reset_mid_dir", 4'b0000);
    send(8'h72, 1'b0);
    check_dir("post_reset_72_unmapped", 4'b0000);
    check("post_reset_held", 8'(heldKeys), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
